// File: rtl/adder_cla_pipe_if.sv
// Operand/result handshake bundle for adder_cla_pipe.
// Optional ADDER_CLA_PIPE_OVF_EN adds the registered signed-overflow flag ovf.
interface adder_cla_pipe_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out;

`ifdef ADDER_CLA_PIPE_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, x, y, cin, out_ready,
        input  in_ready, out_valid, out, ovf
    );
    modport slave (
        input  in_valid, x, y, cin, out_ready,
        output in_ready, out_valid, out, ovf
    );
`else
    modport master (
        output in_valid, x, y, cin, out_ready,
        input  in_ready, out_valid, out
    );
    modport slave (
        input  in_valid, x, y, cin, out_ready,
        output in_ready, out_valid, out
    );
`endif
endinterface

// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder: N/G stages, one G-bit lookahead group per stage.
// Optional ADDER_CLA_PIPE_OVF_EN registers the signed-overflow flag alongside out.
module adder_cla_pipe #(
    parameter int unsigned N = 16,
    parameter int unsigned G = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_cla_pipe_if.slave  bus
);
    localparam int unsigned S = N / G;

    logic advance;
    logic out_valid_w;

    // Returns carries c[0..G] in sum-of-products form: c[i+1] = OR_j g[j]*p[j+1..i] | p[0..i]*ci.
    function automatic logic [G:0] cla_carries(input logic [G-1:0] p,
                                               input logic [G-1:0] g,
                                               input logic         ci);
        logic [G:0] c;
        logic       term;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < G; i++) begin
            term = ci;
            for (int unsigned m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    assign advance      = bus.out_ready || !out_valid_w;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [G-1:0]         gx;
        logic [G-1:0]         gy;
        logic                 ci;
        logic                 vin;
        logic [G-1:0]         gp;
        logic [G-1:0]         gg;
        logic [G:0]           c;
        logic [G-1:0]         gsum;
        logic [(k+1)*G-1:0]   sum_d;
        logic [(k+1)*G-1:0]   sum_q;
        logic                 carry_q;
        logic                 valid_q;

        if (k == 0) begin : g_src
            assign gx    = bus.x[G-1:0];
            assign gy    = bus.y[G-1:0];
            assign ci    = bus.cin;
            assign vin   = bus.in_valid;
            assign sum_d = gsum;
        end else begin : g_src
            assign gx    = g_stage[k-1].g_skew.x_q[G-1:0];
            assign gy    = g_stage[k-1].g_skew.y_q[G-1:0];
            assign ci    = g_stage[k-1].carry_q;
            assign vin   = g_stage[k-1].valid_q;
            assign sum_d = {gsum, g_stage[k-1].sum_q};
        end

        always_comb begin
            gp   = gx ^ gy;
            gg   = gx & gy;
            c    = cla_carries(gp, gg, ci);
            gsum = gp ^ c[G-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= vin;
                carry_q <= c[G];
                sum_q   <= sum_d;
            end
        end

        // Operand bits above this stage's group ride along until their stage arrives.
        if (k < S - 1) begin : g_skew
            localparam int unsigned REM = N - (k + 1) * G;
            logic [REM-1:0] x_d;
            logic [REM-1:0] y_d;
            logic [REM-1:0] x_q;
            logic [REM-1:0] y_q;

            if (k == 0) begin : g_in
                assign x_d = bus.x[N-1:G];
                assign y_d = bus.y[N-1:G];
            end else begin : g_in
                assign x_d = g_stage[k-1].g_skew.x_q[REM+G-1:G];
                assign y_d = g_stage[k-1].g_skew.y_q[REM+G-1:G];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (advance) begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end
        end

`ifdef ADDER_CLA_PIPE_OVF_EN
        if (k == S - 1) begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= c[G] ^ c[G-1];
                end
            end
        end
`endif
    end

    assign out_valid_w   = g_stage[S-1].valid_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out       = {g_stage[S-1].carry_q, g_stage[S-1].sum_q};
`ifdef ADDER_CLA_PIPE_OVF_EN
    assign bus.ovf       = g_stage[S-1].g_ovf.ovf_q;
`endif
endmodule

// File: tb/tb_adder_cla_pipe.sv
// Directed-vector bench for adder_cla_pipe (N=16, G=4, four stages).
// Overflow checks are compiled in when ADDER_CLA_PIPE_OVF_EN is defined.
module tb_adder_cla_pipe;
    logic        clk = 1'b0;
    logic        rst;
    int unsigned checks = 0;
    int unsigned passed = 0;

    adder_cla_pipe_if #(.N(16)) bus ();

    adder_cla_pipe #(.N(16), .G(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        bus.in_valid = v;
        bus.x        = a;
        bus.y        = b;
        bus.cin      = ci;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else passed++;
        checks++;
        if (bus.out !== 17'h0) $display("FAIL reset_out: got %h want 00000", bus.out);
        else passed++;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else passed++;
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL reset_override_%0d: out_valid got %b want 0", i, bus.out_valid);
            else passed++;
        end
    endtask

    task automatic test_full_carry();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            checks++;
            if (bus.out_valid !== (i == 4))
                $display("FAIL latency_cycle_%0d: out_valid got %b want %b", i, bus.out_valid, (i == 4));
            else passed++;
        end
        checks++;
        if (bus.out !== 17'h10000) $display("FAIL full_carry: got %h want 10000", bus.out);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL full_carry_drain: out_valid got %b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h1234, 16'h4321, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h05555)
            $display("FAIL b2b_first: got v=%b %h want v=1 05555", bus.out_valid, bus.out);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h1FFFF)
            $display("FAIL b2b_all_ones: got v=%b %h want v=1 1ffff", bus.out_valid, bus.out);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_bubbles();
        drive(1'b1, 16'h0FFF, 16'h0001, 1'b0);
        tick();
        drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
        tick();
        drive(1'b1, 16'h00FF, 16'h0F01, 1'b1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h01000)
            $display("FAIL bubble_slot0: got v=%b %h want v=1 01000", bus.out_valid, bus.out);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bubble_slot1: out_valid got %b want 0", bus.out_valid);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h01001)
            $display("FAIL bubble_slot2: got v=%b %h want v=1 01001", bus.out_valid, bus.out);
        else passed++;
        tick();
    endtask

    task automatic test_stall();
        logic [16:0] exp_drain [4];
        exp_drain = '{17'h03333, 17'h10000, 17'h00101, 17'h0FFFF};
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h0010, 16'h0020, 1'b0);
        tick();
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        tick();
        drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        tick();
        drive(1'b1, 16'h00FF, 16'h0001, 1'b1);
        tick();
        drive(1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", bus.in_ready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 17'h00030 || bus.in_ready !== 1'b0)
                $display("FAIL stall_hold_%0d: got v=%b %h rdy=%b want v=1 00030 rdy=0",
                         i, bus.out_valid, bus.out, bus.in_ready);
            else passed++;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        else passed++;
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exp_drain[i])
                $display("FAIL stall_drain_%0d: got v=%b %h want v=1 %h",
                         i, bus.out_valid, bus.out, exp_drain[i]);
            else passed++;
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL stall_empty: out_valid got %b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 16'h1111, 16'h1111, 1'b0);
        tick();
        drive(1'b1, 16'h2222, 16'h2222, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b1, 16'h3333, 16'h3333, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 17'h0)
            $display("FAIL midreset_now: got v=%b %h want v=0 00000", bus.out_valid, bus.out);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL midreset_stale_%0d: out_valid got %b want 0", i, bus.out_valid);
            else passed++;
        end
    endtask

`ifdef ADDER_CLA_PIPE_OVF_EN
    task automatic test_ovf();
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h08000 || bus.ovf !== 1'b1)
            $display("FAIL ovf_pos: got v=%b %h ovf=%b want v=1 08000 ovf=1",
                     bus.out_valid, bus.out, bus.ovf);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 17'h10000 || bus.ovf !== 1'b0)
            $display("FAIL ovf_none: got v=%b %h ovf=%b want v=1 10000 ovf=0",
                     bus.out_valid, bus.out, bus.ovf);
        else passed++;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        test_reset();
        test_full_carry();
        test_back_to_back();
        test_bubbles();
        test_stall();
        test_reset_midflight();
`ifdef ADDER_CLA_PIPE_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
